// File: rtl/wb8_pkg.sv
// rtl/wb8_pkg.sv - shared widths, SPU32 address map and arbiter state type for the 8-bit Wishbone interconnect
package wb8_pkg;

    localparam int WB_DATA_W = 8;
    localparam int WB_ADDR_W = 32;

    // Standard SPU32 peripheral map (base / compare mask)
    localparam logic [31:0] ROM_BASE    = 32'hFFFF_F000;
    localparam logic [31:0] ROM_MASK    = 32'hFFFF_F800;
    localparam logic [31:0] UART_BASE   = 32'hFFFF_F800;
    localparam logic [31:0] UART_MASK   = 32'hFFFF_FF00;
    localparam logic [31:0] SPI_BASE    = 32'hFFFF_F900;
    localparam logic [31:0] SPI_MASK    = 32'hFFFF_FF00;
    localparam logic [31:0] TIMER_BASE  = 32'hFFFF_FD00;
    localparam logic [31:0] TIMER_MASK  = 32'hFFFF_FF00;
    localparam logic [31:0] GPIO_BASE   = 32'hFFFF_FE00;
    localparam logic [31:0] GPIO_MASK   = 32'hFFFF_FFF0;
    localparam logic [31:0] BUTTON_BASE = 32'hFFFF_FFE0;
    localparam logic [31:0] BUTTON_MASK = 32'hFFFF_FFF0;
    localparam logic [31:0] LEDS_BASE   = 32'hFFFF_FFF0;
    localparam logic [31:0] LEDS_MASK   = 32'hFFFF_FFF0;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_OWNED = 1'b1
    } arb_state_t;

    function automatic logic addr_match(input logic [31:0] adr,
                                        input logic [31:0] base,
                                        input logic [31:0] mask);
        return (adr & mask) == (base & mask);
    endfunction

endpackage

// File: rtl/wb8_rr_arbiter.sv
// rtl/wb8_rr_arbiter.sv - round-robin bus ownership FSM for N masters
//
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   req[N]      per-master request (CYC)
//   rel         current owner gives up the bus this cycle
//   owner       index of the owning master
//   valid       an owner holds the bus
module wb8_rr_arbiter
    import wb8_pkg::*;
#(
    parameter int N = 2,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [N-1:0]  req,
    input  logic          rel,
    output logic [IW-1:0] owner,
    output logic          valid
);

    arb_state_t    state, state_next;
    logic [IW-1:0] owner_q, owner_next;
    logic [IW-1:0] last_grant, last_next;
    logic [IW-1:0] rr_base, pick;
    logic [2*N-1:0] rr_dbl;
    logic [N-1:0]  rr_rot;
    logic          pick_found;
    int            rr_off;

    // Rotate the request vector so bit 0 is the master after rr_base; the
    // lowest set bit of the rotated vector is then the round-robin winner.
    // On a hand-off the outgoing owner becomes the search base directly.
    always_comb begin
        rr_base    = (state == ARB_OWNED) ? owner_q : last_grant;
        rr_dbl     = {req, req} >> (int'(rr_base) + 1);
        rr_rot     = rr_dbl[N-1:0];
        rr_off     = 0;
        pick_found = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            if (rr_rot[k]) begin
                rr_off     = k;
                pick_found = 1'b1;
            end
        end
        pick = IW'((int'(rr_base) + 1 + rr_off) % N);
    end

    always_comb begin
        state_next = state;
        owner_next = owner_q;
        last_next  = last_grant;
        case (state)
            ARB_IDLE: begin
                if (pick_found) begin
                    owner_next = pick;
                    state_next = ARB_OWNED;
                end
            end
            ARB_OWNED: begin
                if (rel) begin
                    last_next = owner_q;
                    if (pick_found) begin
                        owner_next = pick;
                    end else begin
                        state_next = ARB_IDLE;
                    end
                end
            end
            default: state_next = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ARB_IDLE;
            owner_q    <= '0;
            last_grant <= IW'(N - 1);
        end else begin
            state      <= state_next;
            owner_q    <= owner_next;
            last_grant <= last_next;
        end
    end

    assign owner = owner_q;
    assign valid = (state == ARB_OWNED);

endmodule

// File: rtl/wb8_interconnect.sv
// rtl/wb8_interconnect.sv - multi-master 8-bit Wishbone interconnect with address decode and bus watchdog
//
// Ports:
//   I_wb_clk, I_reset_n             clock, asynchronous active-low reset
//   I_m_cyc/stb/we/adr/dat          per-master request side (flattened)
//   O_m_dat/ack/stall               per-master response side (flattened)
//   O_s_adr/dat/we, O_s_stb         shared slave request, one-hot strobe
//   I_s_dat/ack/stall               per-slave response side (flattened)
//   O_err, O_err_adr                watchdog timeout pulse and address of the timed-out access
module wb8_interconnect
    import wb8_pkg::*;
#(
    parameter int                    NMASTERS       = 2,
    parameter int                    NSLAVES        = 8,
    parameter logic [32*NSLAVES-1:0] SLAVE_BASE     = {NSLAVES{32'h0}},
    parameter logic [32*NSLAVES-1:0] SLAVE_MASK     = {NSLAVES{32'h0}},
    parameter int                    DEFAULT_SLAVE  = NSLAVES - 1,
    parameter int                    TIMEOUT_CYCLES = 255,
    parameter logic [7:0]            ERR_DATA       = 8'hFF
) (
    input  logic                  I_wb_clk,
    input  logic                  I_reset_n,
    input  logic [NMASTERS-1:0]   I_m_cyc,
    input  logic [NMASTERS-1:0]   I_m_stb,
    input  logic [NMASTERS-1:0]   I_m_we,
    input  logic [32*NMASTERS-1:0] I_m_adr,
    input  logic [8*NMASTERS-1:0] I_m_dat,
    output logic [8*NMASTERS-1:0] O_m_dat,
    output logic [NMASTERS-1:0]   O_m_ack,
    output logic [NMASTERS-1:0]   O_m_stall,
    output logic [31:0]           O_s_adr,
    output logic [7:0]            O_s_dat,
    output logic                  O_s_we,
    output logic [NSLAVES-1:0]    O_s_stb,
    input  logic [8*NSLAVES-1:0]  I_s_dat,
    input  logic [NSLAVES-1:0]    I_s_ack,
    input  logic [NSLAVES-1:0]    I_s_stall,
    output logic                  O_err,
    output logic [31:0]           O_err_adr
);

    localparam int          MW      = (NMASTERS > 1) ? $clog2(NMASTERS) : 1;
    localparam int          SW      = (NSLAVES > 1) ? $clog2(NSLAVES) : 1;
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [MW-1:0] owner;
    logic          granted, rel;
    logic          own_cyc, own_stb, own_we;
    logic [31:0]   own_adr;
    logic [7:0]    own_dat;
    logic [SW-1:0] sel;
    logic          s_ack, s_stall;
    logic [7:0]    s_dat;
    logic          outstanding;
    logic [31:0]   out_adr;
    logic [15:0]   to_cnt;
    logic          qual_ack, timeout_fire, issue;

    wb8_rr_arbiter #(.N(NMASTERS)) u_arb (
        .clk   (I_wb_clk),
        .rst_n (I_reset_n),
        .req   (I_m_cyc),
        .rel   (rel),
        .owner (owner),
        .valid (granted)
    );

    always_comb begin
        own_cyc = I_m_cyc[owner];
        own_stb = I_m_stb[owner];
        own_we  = I_m_we[owner];
        own_adr = I_m_adr[32*owner +: 32];
        own_dat = I_m_dat[8*owner +: 8];
    end

    // Scan downwards so the lowest-index match is the one left standing.
    always_comb begin
        sel = SW'(DEFAULT_SLAVE);
        for (int i = NSLAVES - 1; i >= 0; i--) begin
            if (addr_match(own_adr, SLAVE_BASE[32*i +: 32], SLAVE_MASK[32*i +: 32])) begin
                sel = SW'(i);
            end
        end
    end

    assign s_ack   = I_s_ack[sel];
    assign s_stall = I_s_stall[sel];
    assign s_dat   = I_s_dat[8*sel +: 8];

    // A slave ack only counts against an access we actually issued, so late
    // acks after a timeout are swallowed here.
    assign qual_ack     = granted & outstanding & s_ack;
    assign timeout_fire = granted & (own_stb | outstanding) & (to_cnt == TO_LAST) & ~qual_ack;
    assign issue        = granted & own_stb & ~s_stall & ~timeout_fire;
    assign rel          = ~own_cyc & ~outstanding;

    always_comb begin
        O_m_dat   = '0;
        O_m_ack   = '0;
        O_m_stall = '1;
        O_s_stb   = '0;
        if (granted) begin
            O_m_dat[8*owner +: 8] = timeout_fire ? ERR_DATA : s_dat;
            O_m_ack[owner]        = qual_ack | timeout_fire;
            O_m_stall[owner]      = s_stall;
            O_s_stb[sel]          = own_stb & ~timeout_fire;
        end
    end

    assign O_s_adr = own_adr;
    assign O_s_dat = own_dat;
    assign O_s_we  = own_we;
    assign O_err   = timeout_fire;

    always_ff @(posedge I_wb_clk or negedge I_reset_n) begin
        if (!I_reset_n) begin
            outstanding <= 1'b0;
            out_adr     <= '0;
            to_cnt      <= '0;
            O_err_adr   <= '0;
        end else begin
            if (issue) begin
                outstanding <= 1'b1;
                out_adr     <= own_adr;
            end else if (qual_ack | timeout_fire) begin
                outstanding <= 1'b0;
            end

            if (!granted || rel || qual_ack || timeout_fire) begin
                to_cnt <= '0;
            end else if (own_stb | outstanding) begin
                to_cnt <= to_cnt + 16'd1;
            end

            // A still-stalled access never latched its address, so report the live one.
            if (timeout_fire) begin
                O_err_adr <= outstanding ? out_adr : own_adr;
            end
        end
    end

endmodule

// File: tb/tb_wb8_interconnect.sv
// tb/tb_wb8_interconnect.sv - scoreboard bench for wb8_interconnect
module tb_wb8_interconnect;
    import wb8_pkg::*;

    localparam logic [255:0] BASES = {LEDS_BASE, 32'h0000_0000, BUTTON_BASE, GPIO_BASE,
                                      TIMER_BASE, SPI_BASE, UART_BASE, ROM_BASE};
    localparam logic [255:0] MASKS = {LEDS_MASK, 32'hFFFF_FFFF, BUTTON_MASK, GPIO_MASK,
                                      TIMER_MASK, SPI_MASK, UART_MASK, ROM_MASK};

    logic        clk;
    logic        rst_n;
    logic [1:0]  m_cyc, m_stb, m_we;
    logic [63:0] m_adr;
    logic [15:0] m_dat;
    logic [15:0] o_m_dat;
    logic [1:0]  o_m_ack, o_m_stall;
    logic [31:0] o_s_adr;
    logic [7:0]  o_s_dat;
    logic        o_s_we;
    logic [7:0]  o_s_stb;
    logic [63:0] s_dat;
    logic [7:0]  s_ack, s_stall;
    logic        o_err;
    logic [31:0] o_err_adr;

    typedef struct {
        int         m;
        logic [7:0] d;
        logic       err;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   vectors = 0;
    int   fails   = 0;

    wb8_interconnect #(
        .NMASTERS       (2),
        .NSLAVES        (8),
        .SLAVE_BASE     (BASES),
        .SLAVE_MASK     (MASKS),
        .DEFAULT_SLAVE  (7),
        .TIMEOUT_CYCLES (16),
        .ERR_DATA       (8'hFF)
    ) dut (
        .I_wb_clk  (clk),
        .I_reset_n (rst_n),
        .I_m_cyc   (m_cyc),
        .I_m_stb   (m_stb),
        .I_m_we    (m_we),
        .I_m_adr   (m_adr),
        .I_m_dat   (m_dat),
        .O_m_dat   (o_m_dat),
        .O_m_ack   (o_m_ack),
        .O_m_stall (o_m_stall),
        .O_s_adr   (o_s_adr),
        .O_s_dat   (o_s_dat),
        .O_s_we    (o_s_we),
        .O_s_stb   (o_s_stb),
        .I_s_dat   (s_dat),
        .I_s_ack   (s_ack),
        .I_s_stall (s_stall),
        .O_err     (o_err),
        .O_err_adr (o_err_adr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic drv_m(input int m, input logic cyc, input logic stb, input logic we,
                         input logic [31:0] adr, input logic [7:0] dat);
        m_cyc[m]          = cyc;
        m_stb[m]          = stb;
        m_we[m]           = we;
        m_adr[32*m +: 32] = adr;
        m_dat[8*m +: 8]   = dat;
    endtask

    task automatic exp_push(input int m, input logic [7:0] d, input logic err);
        exp_t e;
        e.m   = m;
        e.d   = d;
        e.err = err;
        exp_q.push_back(e);
    endtask

    // Called the cycle after the access was accepted: slave acks once, then
    // the master drops CYC. Returns at the start of the release cycle.
    task automatic complete(input int m, input int s, input logic [7:0] d);
        m_stb[m]        = 1'b0;
        exp_push(m, d, 1'b0);
        s_ack[s]        = 1'b1;
        s_dat[8*s +: 8] = d;
        sample();
        check("other_master_stalled", 32'(o_m_stall[1-m]), 32'd1);
        step();
        s_ack[s] = 1'b0;
        m_cyc[m] = 1'b0;
    endtask

    // Monitor: every ack seen by a master must match the head of the queue.
    always @(negedge clk) begin
        if (o_m_ack != 2'b00) begin
            if (exp_q.size() == 0) begin
                vectors++;
                fails++;
                $display("FAIL unexpected_ack: got ack %b data %h, expected no ack at %0t",
                         o_m_ack, o_m_dat, $time);
            end else begin
                mon_e = exp_q.pop_front();
                check("ack_master", 32'(o_m_ack), 32'(1) << mon_e.m);
                check("ack_data", 32'(o_m_dat[8*mon_e.m +: 8]), 32'(mon_e.d));
                check("ack_other_lane", 32'(o_m_dat[8*(1-mon_e.m) +: 8]), 32'd0);
                check("ack_err", 32'(o_err), 32'(mon_e.err));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        rst_n   = 1'b0;
        m_cyc   = '0;
        m_stb   = '0;
        m_we    = '0;
        m_adr   = '0;
        m_dat   = '0;
        s_dat   = '0;
        s_ack   = '0;
        s_stall = '0;

        // Reset state
        #12;
        check("rst_ack", 32'(o_m_ack), 32'd0);
        check("rst_stb", 32'(o_s_stb), 32'd0);
        check("rst_stall", 32'(o_m_stall), 32'h3);
        check("rst_err", 32'(o_err), 32'd0);
        check("rst_err_adr", o_err_adr, 32'd0);
        step();
        step();
        rst_n = 1'b1;

        // Tie from reset: M0 wins, M1 is handed the bus on release, next tie goes to M0
        drv_m(0, 1'b1, 1'b1, 1'b0, GPIO_BASE, 8'h00);
        drv_m(1, 1'b1, 1'b1, 1'b0, SPI_BASE, 8'h00);
        sample();
        check("tie_grant_latency", 32'(o_m_stall), 32'h3);
        check("tie_latency_no_stb", 32'(o_s_stb), 32'h00);
        step();
        sample();
        check("tie_m0_first", 32'(o_m_stall), 32'h2);
        check("tie_stb_gpio", 32'(o_s_stb), 32'h10);
        step();
        complete(0, 4, 8'h11);
        sample();
        check("tie_m1_waits", 32'(o_m_stall[1]), 32'd1);
        check("tie_release_no_stb", 32'(o_s_stb), 32'h00);
        step();
        sample();
        check("handoff_m1", 32'(o_m_stall), 32'h1);
        check("handoff_stb_spi", 32'(o_s_stb), 32'h04);
        step();
        complete(1, 2, 8'h22);
        step();
        drv_m(0, 1'b1, 1'b1, 1'b0, ROM_BASE + 32'h4, 8'h00);
        drv_m(1, 1'b1, 1'b1, 1'b0, UART_BASE + 32'h10, 8'h00);
        sample();
        step();
        sample();
        check("tie2_m0_first", 32'(o_m_stall), 32'h2);
        check("tie2_stb_rom", 32'(o_s_stb), 32'h01);
        step();
        complete(0, 0, 8'h33);
        step();
        sample();
        check("tie2_stb_uart", 32'(o_s_stb), 32'h02);
        step();
        complete(1, 1, 8'h44);
        step();

        // M0 reads the LEDS slave
        drv_m(0, 1'b1, 1'b1, 1'b0, LEDS_BASE, 8'h00);
        sample();
        check("leds_grant_latency", 32'(o_m_stall), 32'h3);
        step();
        sample();
        check("leds_stb", 32'(o_s_stb), 32'h80);
        check("leds_stall", 32'(o_m_stall), 32'h2);
        check("leds_adr", o_s_adr, LEDS_BASE);
        step();
        complete(0, 7, 8'h5A);
        step();

        // Unmapped address falls through to the default slave
        drv_m(0, 1'b1, 1'b1, 1'b0, 32'h0000_1234, 8'h00);
        sample();
        step();
        sample();
        check("default_stb", 32'(o_s_stb), 32'h80);
        step();
        complete(0, 7, 8'h77);
        check("default_no_err_adr", o_err_adr, 32'd0);
        step();

        // Timeout: slave never acks, error ack on the 16th cycle, late ack dropped
        drv_m(0, 1'b1, 1'b1, 1'b0, TIMER_BASE + 32'h40, 8'h00);
        sample();
        step();
        sample();
        check("to_stb_timer", 32'(o_s_stb), 32'h08);
        exp_push(0, 8'hFF, 1'b1);
        for (int c = 1; c <= 14; c++) begin
            step();
            if (c == 1) m_stb[0] = 1'b0;
            sample();
        end
        check("to_no_early_err", 32'(o_err), 32'd0);
        step();
        sample();
        check("to_err_pulse", 32'(o_err), 32'd1);
        check("to_err_ack", 32'(o_m_ack), 32'h1);
        step();
        sample();
        check("to_err_single", 32'(o_err), 32'd0);
        check("to_err_adr", o_err_adr, TIMER_BASE + 32'h40);
        for (int c = 17; c <= 19; c++) begin
            step();
            sample();
        end
        step();
        s_ack[3]       = 1'b1;
        s_dat[31:24]   = 8'h99;
        sample();
        check("to_late_ack_dropped", 32'(o_m_ack), 32'd0);
        step();
        s_ack[3] = 1'b0;
        m_cyc[0] = 1'b0;
        step();

        // Stalled write: three stall cycles, then a single ack
        s_stall[1] = 1'b1;
        drv_m(1, 1'b1, 1'b1, 1'b1, UART_BASE + 32'h4, 8'hA5);
        sample();
        for (int c = 0; c < 3; c++) begin
            step();
            sample();
            check("wr_stalled", 32'(o_m_stall), 32'h3);
            check("wr_dat_held", 32'(o_s_dat), 32'hA5);
        end
        check("wr_we", 32'(o_s_we), 32'd1);
        step();
        s_stall[1] = 1'b0;
        sample();
        check("wr_accept", 32'(o_m_stall), 32'h1);
        check("wr_stb_uart", 32'(o_s_stb), 32'h02);
        step();
        complete(1, 1, 8'h00);
        s_ack[1] = 1'b1;
        sample();
        check("wr_no_second_ack", 32'(o_m_ack), 32'd0);
        step();
        s_ack[1] = 1'b0;

        // Asynchronous reset while M1 owns the bus with a stalled access
        s_stall[7] = 1'b1;
        drv_m(1, 1'b1, 1'b1, 1'b0, LEDS_BASE + 32'h4, 8'h00);
        sample();
        step();
        drv_m(0, 1'b1, 1'b1, 1'b0, BUTTON_BASE + 32'h4, 8'h00);
        sample();
        check("rst_mid_m1_owns", 32'(o_s_stb), 32'h80);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_async_stb", 32'(o_s_stb), 32'h00);
        check("rst_async_ack", 32'(o_m_ack), 32'd0);
        check("rst_async_stall", 32'(o_m_stall), 32'h3);
        check("rst_async_err_adr", o_err_adr, 32'd0);
        step();
        s_stall[7] = 1'b0;
        rst_n      = 1'b1;
        sample();
        check("post_rst_latency", 32'(o_m_stall), 32'h3);
        step();
        sample();
        check("post_rst_m0_first", 32'(o_m_stall), 32'h2);
        check("post_rst_stb_button", 32'(o_s_stb), 32'h20);
        step();
        complete(0, 5, 8'h66);
        step();
        sample();
        check("post_rst_m1_next", 32'(o_s_stb), 32'h80);
        step();
        complete(1, 7, 8'h55);
        step();
        step();

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule

// File: doc/wb8_interconnect.md
Name: wb8_interconnect

Overview:
Parametrised 8-bit Wishbone interconnect: multi-master round-robin arbiter plus mask/base address decoder feeding NSLAVES peripherals. It replaces the hand-written per-board casez arbiter in top-level SoC files and adds a second master port for DMA/debug. It also adds a bus-timeout watchdog, so an unmapped or hung slave can no longer lock up the CPU.

Parameters:
NMASTERS, 2, number of master ports; index 0 wins ties after reset.
NSLAVES, 8, number of slave ports.
SLAVE_BASE, {NSLAVES{32'h0}}, flattened 32*NSLAVES base addresses; slave i = bits [32*i+31:32*i].
SLAVE_MASK, {NSLAVES{32'h0}}, flattened 32*NSLAVES masks; 1 = compared bit.
DEFAULT_SLAVE, NSLAVES-1, slave selected when no base/mask matches (RAM).
TIMEOUT_CYCLES, 255, cycles without ack before an error ack is generated; range 2..65535.
ERR_DATA, 8'hFF, read data returned on a timeout.

Ports:
I_wb_clk  in  1  bus clock.
I_reset_n  in  1  reset, asynchronous assert, active-low.
I_m_cyc  in  NMASTERS  per-master CYC.
I_m_stb  in  NMASTERS  per-master STB.
I_m_we  in  NMASTERS  per-master WE.
I_m_adr  in  32*NMASTERS  per-master address.
I_m_dat  in  8*NMASTERS  per-master write data.
O_m_dat  out  8*NMASTERS  read data; only the granted master's lane is valid, all other lanes are 0.
O_m_ack  out  NMASTERS  ack, one-hot or zero.
O_m_stall  out  NMASTERS  stall; 1 for every master not currently granted.
O_s_adr  out  32  granted master's address.
O_s_dat  out  8  granted master's write data.
O_s_we  out  1  granted master's WE.
O_s_stb  out  NSLAVES  one-hot strobe.
I_s_dat  in  8*NSLAVES  slave read data.
I_s_ack  in  NSLAVES  slave ack.
I_s_stall  in  NSLAVES  slave stall.
O_err  out  1  one-cycle pulse when a timeout fires.
O_err_adr  out  32  address of the most recent timed-out access; held until the next timeout.

Behaviour:
- Reset values (asynchronous, while I_reset_n=0):
  - grant state IDLE, last_grant = NMASTERS-1, outstanding = 0, timeout counter = 0;
  - O_err = 0, O_err_adr = 0;
  - O_m_ack = 0, O_s_stb = 0, O_m_stall = all 1.
- Arbiter FSM:
  - IDLE: if any I_m_cyc is high, pick the first requesting master searching from last_grant+1 with wrap, register it as owner, go to OWNED. Grant latency is 1 cycle, and O_m_stall stays 1 during that cycle.
  - OWNED: the owner's signals are routed combinationally to the slave side. Go back to IDLE when the owner's cyc drops and outstanding=0; last_grant is updated to the owner on that transition.
  - There is no pre-emption: the owner holds the bus for its whole CYC.
- Decode:
  - Combinational on the owner's address: slave i matches when (adr & MASK_i) == (BASE_i & MASK_i).
  - The lowest-index match wins. If nothing matches, DEFAULT_SLAVE is selected.
- Routing:
  - O_s_stb[sel] = owner stb & ~timeout_fire.
  - O_m_stall[owner] = I_s_stall[sel].
  - O_m_ack[owner] = (I_s_ack[sel] & outstanding) | timeout_fire.
  - The owner's O_m_dat lane = I_s_dat[sel], or ERR_DATA on timeout_fire.
- Outstanding tracking:
  - outstanding is set on owner stb & ~stall.
  - It is cleared by the qualified ack or by timeout_fire.
  - Exactly one outstanding transaction is supported (the CPU is single-issue). A slave ack arriving when outstanding=0 (e.g. a late ack after a timeout) is dropped and never reaches any master.
  - The address of the outstanding access is latched when it is issued and held for error reporting.
- Timeout:
  - The 16-bit counter increments while OWNED and (stb | outstanding) and no qualified ack. It clears on an ack, on leaving OWNED, or on fire.
  - timeout_fire is asserted when counter == TIMEOUT_CYCLES-1 and no ack arrives that cycle; ack has priority in the same cycle.
  - On fire: O_err pulses for one cycle, and O_err_adr takes the latched address, or the current address if the access is still stalled.
- Simultaneous events:
  - A request arriving in the same cycle the owner releases is granted in the next cycle per round-robin.
  - A master dropping cyc while an access is outstanding stays owner until the ack or the timeout.
- Width rules: all address compares are full 32-bit; the counter saturates logically at fire.

Decomposition:
- Shared package wb8_pkg: WB_DATA_W=8, WB_ADDR_W=32, and the localparams for the standard SPU32 address map (ROM FFFFF000/FFFFF800 mask, UART FFFFF8xx, SPI FFFFF9xx, TIMER FFFFFDxx, GPIO FFFFFE0x, BUTTON FFFFFFEx, LEDS FFFFFFFx).
- One sub-module, wb8_rr_arbiter: round-robin grant FSM with parameter N, inputs req[N], release, and outputs owner index and valid.
- Decoder, routing and watchdog stay in the top module.

Test Plan:
- M0 reads 0xFFFFFFF0 with LEDS slave 7 (base FFFFFFF0, mask FFFFFFF0) acking 1 cycle later with 0x5A -> O_s_stb=8'h80; M0 gets ack and data 0x5A; O_m_stall[1]=1 throughout.
- M0 and M1 both raise cyc in the same cycle from reset -> M0 granted first; after M0 drops cyc, M1 is granted 1 cycle later; the next tie goes to M0.
- Access to an unmapped address 0x00001234 -> routed to DEFAULT_SLAVE 7, whose ack completes normally; O_err stays 0.
- Slave never acks, TIMEOUT_CYCLES=16 -> at 16 cycles after stb, M0 gets ack with data 0xFF, O_err pulses once, O_err_adr=address; a slave ack on cycle 20 is ignored.
- Slave stalls 3 cycles, then acks the write of 0xA5 -> O_s_dat=0xA5 held; exactly one ack reaches the master; outstanding returns to 0.
- I_reset_n pulled low mid-transaction with M1 owning the bus -> all strobes and acks are 0 immediately (asynchronously); after release M0 is granted first.
